// File: rtl/sa_x_feeder_if.sv
`default_nettype none
// sa_x_feeder_if: valid/ready stream of signed X vectors, one 16-bit word per array row (rev 1.0)
interface sa_x_feeder_if #(
  parameter int ROWS = 4,
  parameter int DW   = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic [ROWS*DW-1:0]   s_data;
  logic                 s_last;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface
`default_nettype wire

// File: rtl/sa_x_feeder.sv
`default_nettype none
// sa_x_feeder: converts signed X vectors to magnitude/sign and skews them onto the array rows (rev 1.0)
module sa_x_feeder #(
  parameter int ROWS = 4,
  parameter int DW   = 16
) (
  input  wire                  clk,
  input  wire                  _res,
  input  wire [1:0]            cfg_mode,
  sa_x_feeder_if.slave         s,
  output logic [ROWS*DW-1:0]   x_out,
  output logic [ROWS*2-1:0]    xsign_out,
  output logic [1:0]           mode_out,
  output logic                 busy,
  output logic                 done
);
  localparam int CNTW = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam logic [CNTW-1:0] DRAIN_LOAD = CNTW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic [1:0]      mode_reg, mode_nx;
  logic            done_nx;
  logic            accept;
  logic            conv_m8;
  logic [DW-1:0]   conv_mag  [ROWS];
  logic [1:0]      conv_sign [ROWS];

  function automatic logic [7:0] abs8(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

  assign s.s_ready = (state != DRAIN);
  assign accept    = s.s_valid & s.s_ready;
  assign busy      = (state != IDLE);
  // Outside a burst the array must stop accumulating, so the calc bit is dropped.
  assign mode_out  = busy ? mode_reg : {1'b0, mode_reg[0]};
  // The first beat of a burst converts with the mode being latched on that same edge.
  assign conv_m8   = (state == IDLE) ? cfg_mode[0] : mode_reg[0];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      if (conv_m8) begin
        conv_mag[r]  = {abs8(s.s_data[r*DW+8 +: 8]), abs8(s.s_data[r*DW +: 8])};
        conv_sign[r] = {s.s_data[r*DW+15], s.s_data[r*DW+7]};
      end else begin
        conv_mag[r]  = abs16(s.s_data[r*DW +: 16]);
        conv_sign[r] = {2{s.s_data[r*DW+15]}};
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mode_nx  = mode_reg;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          mode_nx = cfg_mode;
          if (s.s_last) begin
            state_nx = DRAIN;
            cnt_nx   = DRAIN_LOAD;
          end else begin
            state_nx = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept && s.s_last) begin
          state_nx = DRAIN;
          cnt_nx   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        cnt_nx = cnt - 1'b1;
        // Leaving on the edge the counter hits zero, i.e. when the last beat lands on the deepest row.
        if (cnt == CNTW'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge _res) begin
    if (!_res) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_reg <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      mode_reg <= mode_nx;
      done     <= done_nx;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0][DW-1:0] mag_pipe;
    logic [r:0][1:0]    sign_pipe;

    always_ff @(negedge clk or negedge _res) begin
      if (!_res) begin
        mag_pipe  <= '0;
        sign_pipe <= '0;
      end else begin
        mag_pipe[0]  <= accept ? conv_mag[r]  : '0;
        sign_pipe[0] <= accept ? conv_sign[r] : 2'b00;
        for (int j = 1; j <= r; j++) begin
          mag_pipe[j]  <= mag_pipe[j-1];
          sign_pipe[j] <= sign_pipe[j-1];
        end
      end
    end

    assign x_out[r*DW +: DW]   = mag_pipe[r];
    assign xsign_out[r*2 +: 2] = sign_pipe[r];
  end
endmodule
`default_nettype wire
